// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: arbiter FSM states and data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner selection: first requester strictly after ptr, scanning upward with wrap.
module uart_rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        onehot   = '0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        // Offsets 1..NUM_REQ, so the previous winner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter among NUM_REQ byte sources; round-robin per packet,
// with an inter-byte gap after every completion and a per-byte watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 1,
    parameter int TIMEOUT_CLKS = 1200
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_L,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [UART_DATA_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]             i_Req_Last,
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_Tx_DV,
    output logic [UART_DATA_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic                           o_Busy,
    output logic                           o_Timeout_Err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    arb_state_t              state, state_n;
    logic [IDX_W-1:0]        ptr, ptr_n;
    logic                    lock, lock_n;
    logic [TMR_W-1:0]        timer, timer_n;
    logic [GAP_W-1:0]        gap_cnt, gap_n;
    logic [NUM_REQ-1:0]      grant, grant_n;
    logic [NUM_REQ-1:0]      ack, ack_n;
    logic                    tx_dv, tx_dv_n;
    logic [UART_DATA_W-1:0]  tx_byte, tx_byte_n;
    logic                    busy, busy_n;
    logic                    tmo, tmo_n;

    logic                    pick_valid;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic [UART_DATA_W-1:0]  req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = i_Req_Byte[g*UART_DATA_W +: UART_DATA_W];
    end

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (i_Req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // The rr pointer doubles as the owner index while a packet is locked.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        lock_n    = lock;
        timer_n   = timer;
        gap_n     = gap_cnt;
        grant_n   = grant;
        ack_n     = '0;
        tx_dv_n   = 1'b0;
        tx_byte_n = tx_byte;
        tmo_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid && !i_Tx_Active) begin
                    state_n   = ST_WAIT;
                    grant_n   = pick_onehot;
                    ack_n     = pick_onehot;
                    tx_dv_n   = 1'b1;
                    tx_byte_n = req_bytes[pick_idx];
                    lock_n    = !i_Req_Last[pick_idx];
                    ptr_n     = pick_idx;
                    timer_n   = '0;
                end
            end
            ST_WAIT: begin
                if (i_Tx_Done) begin
                    state_n = ST_GAP;
                    timer_n = '0;
                    gap_n   = '0;
                end else if (timer == TMR_LAST) begin
                    state_n = ST_GAP;
                    tmo_n   = 1'b1;
                    grant_n = '0;
                    lock_n  = 1'b0;
                    timer_n = '0;
                    gap_n   = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            ST_GAP: begin
                // Counter parks at its last value while waiting on i_Tx_Active.
                if (gap_cnt != GAP_LAST) begin
                    gap_n = gap_cnt + GAP_W'(1);
                end else if (!lock) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                end else if (!i_Req[ptr]) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    lock_n  = 1'b0;
                end else if (!i_Tx_Active) begin
                    state_n   = ST_WAIT;
                    ack_n     = grant;
                    tx_dv_n   = 1'b1;
                    tx_byte_n = req_bytes[ptr];
                    lock_n    = !i_Req_Last[ptr];
                    timer_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                lock_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= ST_IDLE;
            ptr     <= IDX_W'(NUM_REQ - 1);
            lock    <= 1'b0;
            timer   <= '0;
            gap_cnt <= '0;
            grant   <= '0;
            ack     <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
            busy    <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            lock    <= lock_n;
            timer   <= timer_n;
            gap_cnt <= gap_n;
            grant   <= grant_n;
            ack     <= ack_n;
            tx_dv   <= tx_dv_n;
            tx_byte <= tx_byte_n;
            busy    <= busy_n;
            tmo     <= tmo_n;
        end
    end

    assign o_Ack         = ack;
    assign o_Grant       = grant;
    assign o_Tx_DV       = tx_dv;
    assign o_Tx_Byte     = tx_byte;
    assign o_Busy        = busy;
    assign o_Timeout_Err = tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of round-robin packets plus hand-written
// sequences for locked packets, watchdog, done/expiry collision and async reset.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int GAP_CLKS     = 3;
    localparam int TIMEOUT_CLKS = 1200;

    logic        i_Clock = 1'b0;
    logic        i_Rst_L;
    logic [3:0]  i_Req;
    logic [31:0] i_Req_Byte;
    logic [3:0]  i_Req_Last;
    logic [3:0]  o_Ack;
    logic [3:0]  o_Grant;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        i_Tx_Active;
    logic        i_Tx_Done;
    logic        o_Busy;
    logic        o_Timeout_Err;

    int total  = 0;
    int passed = 0;
    int cycle  = 0;
    int dv_cnt = 0;
    int tmo_cnt = 0;
    int ack_cnt [4] = '{0, 0, 0, 0};

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        int         done_clks;
        logic [3:0] exp_grant;
        logic [7:0] exp_byte;
    } vec_t;

    always #5 i_Clock = ~i_Clock;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Req(i_Req), .i_Req_Byte(i_Req_Byte),
        .i_Req_Last(i_Req_Last), .o_Ack(o_Ack), .o_Grant(o_Grant), .o_Tx_DV(o_Tx_DV),
        .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
        .o_Busy(o_Busy), .o_Timeout_Err(o_Timeout_Err)
    );

    // One clock step; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_Clock);
        #1;
        cycle++;
        if (o_Tx_DV) dv_cnt++;
        if (o_Timeout_Err) tmo_cnt++;
        for (int r = 0; r < 4; r++) if (o_Ack[r]) ack_cnt[r]++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] last, input logic [31:0] bytes);
        i_Req      = req;
        i_Req_Last = last;
        i_Req_Byte = bytes;
    endtask

    task automatic applyReset();
        i_Rst_L     = 1'b0;
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        applyStimulus(4'b0, 4'b0, 32'h0);
        repeat (2) tick();
        i_Rst_L = 1'b1;
    endtask

    task automatic waitLaunch(input string name, output int at);
        int n = 0;
        at = -1;
        while (!o_Tx_DV && n < 64) begin
            tick();
            n++;
        end
        if (o_Tx_DV) at = cycle;
        else checkOutput({name, " launch wait expired"}, 32'd0, 32'd1);
    endtask

    // Done pulse sampled n edges after the launch edge.
    task automatic sendDone(input int n, output int done_at);
        repeat (n - 1) tick();
        i_Tx_Done = 1'b1;
        done_at   = cycle;
        tick();
        i_Tx_Done = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (o_Busy && n < 64) begin
            tick();
            n++;
        end
        checkOutput({name, " idle"}, 32'(o_Busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global time limit: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t vecs [8];
        int   at, d, start, snap_dv, snap_tmo, n;
        int   snap_ack [4];
        logic [15:0] delta, exp_delta;
        logic [31:0] rr_bytes;

        rr_bytes = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        vecs[0] = '{4'b1111, 4'b1111,  10, 4'b0001, 8'hA0};
        vecs[1] = '{4'b1111, 4'b1111,  25, 4'b0010, 8'hB1};
        vecs[2] = '{4'b1111, 4'b1111,  40, 4'b0100, 8'hC2};
        vecs[3] = '{4'b1111, 4'b1111, 100, 4'b1000, 8'hD3};
        vecs[4] = '{4'b1111, 4'b1111,  12, 4'b0001, 8'hA0};
        vecs[5] = '{4'b1010, 4'b1010,  20, 4'b0010, 8'hB1};
        vecs[6] = '{4'b1001, 4'b1001,  20, 4'b1000, 8'hD3};
        vecs[7] = '{4'b0110, 4'b0110,  20, 4'b0010, 8'hB1};

        // Reset values, then a single-byte packet from req0
        applyReset();
        checkOutput("rst dv",    32'(o_Tx_DV),       32'd0);
        checkOutput("rst ack",   32'(o_Ack),         32'd0);
        checkOutput("rst grant", 32'(o_Grant),       32'd0);
        checkOutput("rst busy",  32'(o_Busy),        32'd0);
        checkOutput("rst tmo",   32'(o_Timeout_Err), 32'd0);
        checkOutput("rst byte",  32'(o_Tx_Byte),     32'd0);
        snap_dv = dv_cnt;
        applyStimulus(4'b0001, 4'b0001, 32'h0000_00A5);
        start = cycle;
        waitLaunch("t1", at);
        checkOutput("t1 latency", 32'(at - start), 32'd1);
        checkOutput("t1 byte",  32'(o_Tx_Byte), 32'hA5);
        checkOutput("t1 ack",   32'(o_Ack),     32'b0001);
        checkOutput("t1 grant", 32'(o_Grant),   32'b0001);
        checkOutput("t1 busy",  32'(o_Busy),    32'd1);
        applyStimulus(4'b0000, 4'b0001, 32'h0000_00A5);
        sendDone(870, d);
        checkOutput("t1 grant in gap", 32'(o_Grant), 32'b0001);
        repeat (GAP_CLKS - 1) tick();
        checkOutput("t1 grant gap end-1", 32'(o_Grant), 32'b0001);
        checkOutput("t1 busy gap end-1",  32'(o_Busy),  32'd1);
        tick();
        checkOutput("t1 grant released", 32'(o_Grant), 32'd0);
        checkOutput("t1 busy released",  32'(o_Busy),  32'd0);
        checkOutput("t1 dv count", 32'(dv_cnt - snap_dv), 32'd1);

        // Round-robin packets from a fresh reset
        applyReset();
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 4; r++) snap_ack[r] = ack_cnt[r];
            applyStimulus(vecs[i].req, vecs[i].last, rr_bytes);
            waitLaunch($sformatf("rr%0d", i), at);
            checkOutput($sformatf("rr%0d grant", i), 32'(o_Grant),   32'(vecs[i].exp_grant));
            checkOutput($sformatf("rr%0d byte", i),  32'(o_Tx_Byte), 32'(vecs[i].exp_byte));
            checkOutput($sformatf("rr%0d ack", i),   32'(o_Ack),     32'(vecs[i].exp_grant));
            applyStimulus(4'b0000, vecs[i].last, rr_bytes);
            sendDone(vecs[i].done_clks, d);
            waitIdle($sformatf("rr%0d", i));
            for (int r = 0; r < 4; r++) begin
                delta[4*r +: 4]     = 4'(ack_cnt[r] - snap_ack[r]);
                exp_delta[4*r +: 4] = {3'b000, vecs[i].exp_grant[r]};
            end
            checkOutput($sformatf("rr%0d ack counts", i), 32'(delta), 32'(exp_delta));
        end

        // Locked 3-byte packet from req2 while req0 waits
        for (int r = 0; r < 4; r++) snap_ack[r] = ack_cnt[r];
        applyStimulus(4'b0101, 4'b0001, {8'h00, 8'h11, 8'h00, 8'h55});
        waitLaunch("pkt b0", at);
        checkOutput("pkt b0 byte",  32'(o_Tx_Byte), 32'h11);
        checkOutput("pkt b0 grant", 32'(o_Grant),   32'b0100);
        applyStimulus(4'b0101, 4'b0001, {8'h00, 8'h22, 8'h00, 8'h55});
        sendDone(30, d);
        waitLaunch("pkt b1", at);
        checkOutput("pkt b1 spacing", 32'(at - d), 32'(GAP_CLKS + 1));
        checkOutput("pkt b1 byte", 32'(o_Tx_Byte), 32'h22);
        checkOutput("pkt b1 ack",  32'(o_Ack),     32'b0100);
        applyStimulus(4'b0101, 4'b0101, {8'h00, 8'h33, 8'h00, 8'h55});
        sendDone(30, d);
        waitLaunch("pkt b2", at);
        checkOutput("pkt b2 spacing", 32'(at - d), 32'(GAP_CLKS + 1));
        checkOutput("pkt b2 byte",  32'(o_Tx_Byte), 32'h33);
        checkOutput("pkt b2 grant", 32'(o_Grant),   32'b0100);
        applyStimulus(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h55});
        sendDone(30, d);
        waitLaunch("pkt next", at);
        checkOutput("pkt next byte",  32'(o_Tx_Byte), 32'h55);
        checkOutput("pkt next grant", 32'(o_Grant),   32'b0001);
        checkOutput("pkt ack req2", 32'(ack_cnt[2] - snap_ack[2]), 32'd3);
        checkOutput("pkt ack req0", 32'(ack_cnt[0] - snap_ack[0]), 32'd1);
        applyStimulus(4'b0000, 4'b0001, 32'h0);
        sendDone(15, d);
        waitIdle("pkt");

        // Watchdog expiry, then i_Tx_Active blocks the next launch
        snap_tmo = tmo_cnt;
        applyStimulus(4'b0010, 4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
        waitLaunch("wd", at);
        checkOutput("wd grant", 32'(o_Grant), 32'b0010);
        applyStimulus(4'b0000, 4'b0010, 32'h0);
        i_Tx_Active = 1'b1;
        n = 0;
        while (!o_Timeout_Err && n < TIMEOUT_CLKS + 100) begin
            tick();
            n++;
        end
        checkOutput("wd expiry time", 32'(o_Timeout_Err ? cycle - at : -1), 32'(TIMEOUT_CLKS));
        checkOutput("wd grant dropped", 32'(o_Grant), 32'd0);
        tick();
        checkOutput("wd pulse width", 32'(tmo_cnt - snap_tmo), 32'd1);
        applyStimulus(4'b1000, 4'b1000, {8'h88, 8'h00, 8'h00, 8'h00});
        snap_dv = dv_cnt;
        repeat (20) tick();
        checkOutput("wd blocked by active", 32'(dv_cnt - snap_dv), 32'd0);
        checkOutput("wd busy while blocked", 32'(o_Busy), 32'd0);
        i_Tx_Active = 1'b0;
        waitLaunch("wd after active", at);
        checkOutput("wd after grant", 32'(o_Grant),   32'b1000);
        checkOutput("wd after byte",  32'(o_Tx_Byte), 32'h88);
        applyStimulus(4'b0000, 4'b1000, 32'h0);
        sendDone(15, d);
        waitIdle("wd");

        // Done lands on the exact expiry cycle: done wins
        snap_tmo = tmo_cnt;
        applyStimulus(4'b0001, 4'b0001, 32'h0000_005A);
        waitLaunch("coll", at);
        applyStimulus(4'b0000, 4'b0001, 32'h0);
        sendDone(TIMEOUT_CLKS, d);
        checkOutput("coll grant kept", 32'(o_Grant), 32'b0001);
        waitIdle("coll");
        checkOutput("coll no timeout", 32'(tmo_cnt - snap_tmo), 32'd0);

        // Asynchronous reset mid-WAIT, then req0 beats req3
        applyStimulus(4'b0100, 4'b0100, {8'h00, 8'hC6, 8'h00, 8'h00});
        waitLaunch("arst", at);
        applyStimulus(4'b0000, 4'b0100, 32'h0);
        repeat (5) tick();
        checkOutput("arst pre grant", 32'(o_Grant), 32'b0100);
        #3;
        i_Rst_L = 1'b0;
        #1;
        checkOutput("arst grant", 32'(o_Grant),   32'd0);
        checkOutput("arst busy",  32'(o_Busy),    32'd0);
        checkOutput("arst byte",  32'(o_Tx_Byte), 32'd0);
        @(posedge i_Clock);
        #2;
        i_Rst_L = 1'b1;
        applyStimulus(4'b1001, 4'b1001, {8'hF3, 8'h00, 8'h00, 8'h0F});
        waitLaunch("arst after", at);
        checkOutput("arst after grant", 32'(o_Grant),   32'b0001);
        checkOutput("arst after byte",  32'(o_Tx_Byte), 32'h0F);
        applyStimulus(4'b0000, 4'b1001, 32'h0);
        sendDone(15, d);
        waitIdle("arst after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
